// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
//
// Shared definitions for the seven-segment scan controller:
//   - scan_state_t : the two scan phases of every digit slot
//   - SEG_OFF      : active-low segment pattern with every segment dark
//   - HEX_GLYPHS   : active-high {g,f,e,d,c,b,a} glyphs for nibbles 0..F
//   - counter_width: $clog2 of a count, never narrower than one bit
// ---------------------------------------------------------------------------
package seg7_pkg;

  // BLANK keeps every anode off so the previous digit cannot ghost into the
  // next one; DRIVE lights the selected anode with its decoded glyph.
  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // All segments dark on the active-low segment bus.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Bit order is {g,f,e,d,c,b,a}; letters use the usual A b C d E F shapes
  // so that B and D stay distinguishable from 8 and 0.
  localparam logic [6:0] HEX_GLYPHS [16] = '{
    7'h3F,  // 0
    7'h06,  // 1
    7'h5B,  // 2
    7'h4F,  // 3
    7'h66,  // 4
    7'h6D,  // 5
    7'h7D,  // 6
    7'h07,  // 7
    7'h7F,  // 8
    7'h6F,  // 9
    7'h77,  // A
    7'h7C,  // b
    7'h39,  // C
    7'h5E,  // d
    7'h79,  // E
    7'h71   // F
  };

  // A counter for a range of one value still needs a single bit so that
  // the register declarations never collapse to zero width.
  function automatic int counter_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex_seg_decode.sv
// ---------------------------------------------------------------------------
// hex_seg_decode
//
// Purely combinational nibble-to-glyph decoder.
//
// Ports:
//   nibble  in  4  hex value to display
//   seg     out 7  active-high segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module hex_seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup keeps the glyph shapes in one place (the package) so the
  // decoder and any future users always agree on how each digit looks.
  always_comb begin
    seg = HEX_GLYPHS[nibble];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Every digit owns one REFRESH_DIV-cycle slot per frame; the first
// BLANK_CYCLES of each slot keep all anodes off to stop ghosting. Display
// data is taken from shadow registers that only update at a frame boundary,
// so a frame never shows a mix of old and new values.
//
// Parameters:
//   N_DIGITS      number of scanned digits (1..8)
//   REFRESH_DIV   clock cycles per digit slot
//   BLANK_CYCLES  leading blank cycles per slot (1 <= BLANK_CYCLES < REFRESH_DIV)
//
// Ports:
//   clk         in   1           system clock
//   rst_n       in   1           synchronous active-low reset
//   digits      in   4*N_DIGITS  hex nibble per digit, digit i = [4i+3:4i]
//   digit_en    in   N_DIGITS    per-digit enable, 0 keeps the digit dark
//   dp          in   N_DIGITS    per-digit decimal point, active-high
//   load        in   1           request capture of digits/digit_en/dp
//   an          out  N_DIGITS    anode selects, active-low
//   seg         out  7           segments {g,f,e,d,c,b,a}, active-low
//   dp_n        out  1           decimal point, active-low
//   frame_done  out  1           one-cycle pulse when the scan wraps to digit 0
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*N_DIGITS-1:0]   digits,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic [N_DIGITS-1:0]     dp,
  input  logic                    load,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int CNT_W = counter_width(REFRESH_DIV);
  localparam int IDX_W = counter_width(N_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(N_DIGITS - 1);

  // State encodings kept as plain constants so the register is a bare
  // logic vector, matching older blocks that probe it directly.
  localparam logic [0:0] ST_BLANK = BLANK;
  localparam logic [0:0] ST_DRIVE = DRIVE;

  logic [0:0]            state;
  logic [0:0]            state_next;
  logic [CNT_W-1:0]      slot_cnt;
  logic [IDX_W-1:0]      idx;
  logic                  pending;

  logic [4*N_DIGITS-1:0] shadow_digits;
  logic [N_DIGITS-1:0]   shadow_en;
  logic [N_DIGITS-1:0]   shadow_dp;

  logic                  slot_end;
  logic                  frame_end;
  logic                  capture;

  logic [3:0]            cur_nibble;
  logic                  cur_en;
  logic                  cur_dp;
  logic [N_DIGITS-1:0]   an_sel;
  logic [6:0]            glyph;

  assign slot_end  = (slot_cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // A load on the boundary cycle itself is honoured right away instead of
  // being parked in pending, so the new data shows in the very next frame.
  assign capture   = frame_end && (pending || load);

  // Slot phase: BLANK runs until the last blank cycle, then DRIVE holds
  // until the slot counter wraps back to zero.
  always_comb begin
    state_next = state;
    case (state)
      ST_BLANK: if (slot_cnt == CNT_BLANK_LAST) state_next = ST_DRIVE;
      ST_DRIVE: if (slot_end)                   state_next = ST_BLANK;
      default:                                  state_next = ST_BLANK;
    endcase
  end

  // Scan timing: slot counter, digit index and phase all advance together.
  // Disabled digits still take their full slot so brightness stays even.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_BLANK;
      slot_cnt <= '0;
      idx      <= '0;
    end else begin
      state <= state_next;
      if (slot_end) begin
        slot_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        slot_cnt <= slot_cnt + CNT_W'(1);
      end
    end
  end

  // Load bookkeeping: remember a request until the next frame boundary and
  // capture whatever is on the inputs at that boundary, so repeated strobes
  // simply mean the latest input values win.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending       <= 1'b0;
      shadow_digits <= '0;
      shadow_en     <= '0;
      shadow_dp     <= '0;
    end else begin
      if (frame_end) begin
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
      if (capture) begin
        shadow_digits <= digits;
        shadow_en     <= digit_en;
        shadow_dp     <= dp;
      end
    end
  end

  // Select the current digit's shadow data and build its active-low anode
  // pattern. A compare-per-digit mux avoids index arithmetic that could run
  // past the vector when N_DIGITS is not a power of two.
  always_comb begin
    cur_nibble = 4'h0;
    cur_en     = 1'b0;
    cur_dp     = 1'b0;
    an_sel     = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nibble = shadow_digits[4*i +: 4];
        cur_en     = shadow_en[i];
        cur_dp     = shadow_dp[i];
        an_sel[i]  = 1'b0;
      end
    end
  end

  hex_seg_decode u_decode (
    .nibble (cur_nibble),
    .seg    (glyph)
  );

  // Pin registers: every output comes straight from a flop so the display
  // never sees decode glitches. Outputs follow the scan phase one cycle
  // later, which is why the first lit digit appears one edge after the
  // phase counter enters DRIVE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an         <= '1;
      seg        <= SEG_OFF;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (state == ST_DRIVE) begin
        an   <= cur_en ? an_sel : '1;
        seg  <= ~glyph;
        dp_n <= ~cur_dp;
      end else begin
        an   <= '1;
        seg  <= SEG_OFF;
        dp_n <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//
// Self-checking bench for seg7_scan_ctrl with N_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2. Edge k counts rising edges since reset release; outputs
// after edge k reflect scan position m = k-1 (slot m/8, phase m%8), lit when
// m%8 >= 2. Frame f shows the shadow data captured at edge 32*f.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int N_DIGITS     = 4;
  localparam int REFRESH_DIV  = 8;
  localparam int BLANK_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_done;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  typedef struct {
    int          at_edge;
    logic        ld;
    logic [15:0] dig;
    logic [3:0]  en;
    logic [3:0]  dpv;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp_n;
    logic        exp_fd;
  } vec_t;

  vec_t vecs [13];

  seg7_scan_ctrl #(
    .N_DIGITS     (N_DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits     (digits),
    .digit_en   (digit_en),
    .dp         (dp),
    .load       (load),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Hard stop in case the scan never reaches a checked edge.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runTo(input int k);
    while (cyc < k) tick();
  endtask

  task automatic applyStimulus(input logic ld, input logic [15:0] d,
                               input logic [3:0] en, input logic [3:0] p);
    load     = ld;
    digits   = d;
    digit_en = en;
    dp       = p;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] ea,
                             input logic [6:0] es, input logic edp, input logic efd);
    tests_run++;
    if (an !== ea || seg !== es || dp_n !== edp || frame_done !== efd) begin
      tests_failed++;
      $display("[TB] FAIL %s @edge %0d: got an=%b seg=%b dp_n=%b fd=%b, want an=%b seg=%b dp_n=%b fd=%b",
               name, cyc, an, seg, dp_n, frame_done, ea, es, edp, efd);
    end
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 16'h0, 4'h0, 4'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  function automatic logic [3:0] anode_for(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  initial begin
    logic [6:0] g4321 [4];
    logic [6:0] g7c6d [4];
    logic [3:0] en3;
    logic [3:0] dp3;
    int m;
    int d;
    logic drv;

    // Active-low glyphs per digit position for the data sets used below.
    g4321 = '{7'h79, 7'h24, 7'h30, 7'h19};  // 1 2 3 4
    g7c6d = '{7'h21, 7'h02, 7'h46, 7'h78};  // d 6 C 7
    en3 = 4'b0101;
    dp3 = 4'b0100;

    vecs[0]  = '{0,  1'b1, 16'h4321, 4'hF, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0};
    vecs[1]  = '{1,  1'b0, 16'h4321, 4'hF, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0};
    vecs[2]  = '{3,  1'b0, 16'h4321, 4'hF, 4'h0, 4'hF, 7'h40, 1'b1, 1'b0};
    vecs[3]  = '{32, 1'b0, 16'h4321, 4'hF, 4'h0, 4'hF, 7'h40, 1'b1, 1'b1};
    vecs[4]  = '{33, 1'b0, 16'h4321, 4'hF, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0};
    vecs[5]  = '{35, 1'b0, 16'h4321, 4'hF, 4'h0, 4'hE, 7'h79, 1'b1, 1'b0};
    vecs[6]  = '{40, 1'b0, 16'h4321, 4'hF, 4'h0, 4'hE, 7'h79, 1'b1, 1'b0};
    vecs[7]  = '{41, 1'b0, 16'h4321, 4'hF, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0};
    vecs[8]  = '{43, 1'b0, 16'h4321, 4'hF, 4'h0, 4'hD, 7'h24, 1'b1, 1'b0};
    vecs[9]  = '{51, 1'b0, 16'h4321, 4'hF, 4'h0, 4'hB, 7'h30, 1'b1, 1'b0};
    vecs[10] = '{59, 1'b0, 16'h4321, 4'hF, 4'h0, 4'h7, 7'h19, 1'b1, 1'b0};
    vecs[11] = '{64, 1'b0, 16'h4321, 4'hF, 4'h0, 4'h7, 7'h19, 1'b1, 1'b1};
    vecs[12] = '{65, 1'b0, 16'h4321, 4'hF, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0};

    // Basic load and first two frames, table driven.
    resetDut();
    for (int i = 0; i < 13; i++) begin
      runTo(vecs[i].at_edge);
      checkOutput($sformatf("table[%0d]", i), vecs[i].exp_an, vecs[i].exp_seg,
                  vecs[i].exp_dp_n, vecs[i].exp_fd);
      applyStimulus(vecs[i].ld, vecs[i].dig, vecs[i].en, vecs[i].dpv);
    end

    // Free run three more frames: blanking at the start of every slot and
    // frame_done once every 32 edges.
    for (int k = 66; k <= 161; k++) begin
      runTo(k);
      m   = k - 1;
      d   = (m / 8) % 4;
      drv = (m % 8) >= 2;
      checkOutput("freerun", drv ? anode_for(d) : 4'hF, drv ? g4321[d] : 7'h7F,
                  1'b1, (k % 32) == 0);
    end

    // Partial enables and a single decimal point.
    resetDut();
    applyStimulus(1'b1, 16'h7C6D, en3, dp3);
    tick();
    applyStimulus(1'b0, 16'h7C6D, en3, dp3);
    for (int k = 33; k <= 64; k++) begin
      runTo(k);
      m   = k - 1;
      d   = (m / 8) % 4;
      drv = (m % 8) >= 2;
      checkOutput("enable_dp", (drv && en3[d]) ? anode_for(d) : 4'hF,
                  drv ? g7c6d[d] : 7'h7F, drv ? ~dp3[d] : 1'b1, k == 64);
    end

    // Two loads inside one frame: frame unchanged, next frame shows the
    // value present at the boundary.
    resetDut();
    applyStimulus(1'b1, 16'h4321, 4'hF, 4'h0);
    tick();
    applyStimulus(1'b0, 16'h4321, 4'hF, 4'h0);
    runTo(40);
    checkOutput("midload_d0", 4'hE, 7'h79, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'hABCD, 4'hF, 4'h0);
    tick();
    applyStimulus(1'b0, 16'hABCD, 4'hF, 4'h0);
    runTo(43);
    checkOutput("midload_d1", 4'hD, 7'h24, 1'b1, 1'b0);
    runTo(50);
    applyStimulus(1'b1, 16'hEF01, 4'hF, 4'h0);
    tick();
    applyStimulus(1'b0, 16'hEF01, 4'hF, 4'h0);
    checkOutput("midload_d2", 4'hB, 7'h30, 1'b1, 1'b0);
    runTo(59);
    checkOutput("midload_d3", 4'h7, 7'h19, 1'b1, 1'b0);
    runTo(64);
    checkOutput("midload_fd", 4'h7, 7'h19, 1'b1, 1'b1);
    runTo(67);
    checkOutput("next_d0", 4'hE, 7'h79, 1'b1, 1'b0);
    runTo(75);
    checkOutput("next_d1", 4'hD, 7'h40, 1'b1, 1'b0);
    runTo(83);
    checkOutput("next_d2", 4'hB, 7'h0E, 1'b1, 1'b0);
    runTo(91);
    checkOutput("next_d3", 4'h7, 7'h06, 1'b1, 1'b0);

    // Load on the boundary edge itself: captured at once, and a later
    // input change without load must not be picked up at the next boundary.
    resetDut();
    runTo(31);
    applyStimulus(1'b1, 16'h89AB, 4'hF, 4'h0);
    tick();
    checkOutput("bnd_edge", 4'hF, 7'h40, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'h5555, 4'hF, 4'h0);
    runTo(35);
    checkOutput("bnd_f1_d0", 4'hE, 7'h03, 1'b1, 1'b0);
    runTo(43);
    checkOutput("bnd_f1_d1", 4'hD, 7'h08, 1'b1, 1'b0);
    runTo(67);
    checkOutput("bnd_f2_d0", 4'hE, 7'h03, 1'b1, 1'b0);
    runTo(91);
    checkOutput("bnd_f2_d3", 4'h7, 7'h00, 1'b1, 1'b0);

    // One-cycle reset in the middle of a lit slot.
    rst_n = 1'b0;
    tick();
    checkOutput("rst_mid", 4'hF, 7'h7F, 1'b1, 1'b0);
    rst_n = 1'b1;
    cyc = 0;
    runTo(2);
    checkOutput("rst_blank", 4'hF, 7'h7F, 1'b1, 1'b0);
    runTo(3);
    checkOutput("rst_d0_empty", 4'hF, 7'h40, 1'b1, 1'b0);
    runTo(32);
    checkOutput("rst_frame", 4'hF, 7'h40, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing scan controller for the board's eight-digit common-anode seven-segment display. It shares the single CA..CG/DP segment bus among up to N_DIGITS digit requesters. Each digit gets one fixed-length slot per frame, with a blanking interval between slots to prevent ghosting. It sits between the counter/datapath logic (which supplies hex nibbles) and the display pins, and replaces direct decoder-to-pin wiring.

## Interface
- N_DIGITS, 8, number of scanned digits (1..8)
- REFRESH_DIV, 100_000, clock cycles per digit slot (1 kHz/digit at 100 MHz)
- BLANK_CYCLES, 1_000, leading cycles of each slot with all anodes off; must satisfy 1 ≤ BLANK_CYCLES < REFRESH_DIV
- clk  in  1  system clock (CLK100MHZ)
- rst_n  in  1  synchronous, active-low reset
- digits  in  4*N_DIGITS  hex value per digit; digit i = digits[4i+3:4i]
- digit_en  in  N_DIGITS  per-digit enable; 0 = digit blank for its slot
- dp  in  N_DIGITS  per-digit decimal point, active-high
- load  in  1  strobe: request capture of digits/digit_en/dp into shadow registers
- an  out  N_DIGITS  anode selects, active-low
- seg  out  7  segments {CG,CF,CE,CD,CC,CB,CA}, active-low
- dp_n  out  1  decimal point, active-low
- frame_done  out  1  one-cycle pulse at end of each full scan

## Operation
- The FSM has two states: BLANK and DRIVE. The slot counter runs 0..REFRESH_DIV-1, and the digit index runs 0..N_DIGITS-1.
- BLANK occupies slot counter 0..BLANK_CYCLES-1. In BLANK: an all 1, seg 7'h7F, dp_n 1.
- DRIVE occupies BLANK_CYCLES..REFRESH_DIV-1. In DRIVE: an[idx]=0 if shadow digit_en[idx], else all 1. seg is the decoded shadow nibble, and dp_n = ~shadow dp[idx].
- A disabled digit still consumes its full slot, so brightness stays uniform regardless of how many digits are enabled.
- At slot counter REFRESH_DIV-1, the counter wraps to 0 and the FSM returns to BLANK.
  - idx increments, wrapping N_DIGITS-1 → 0.
  - On the wrap to 0, frame_done pulses for one cycle.
- Shadow update (tear-free):
  - load sets a pending flag.
  - Shadow registers capture the inputs only at a frame boundary (idx wrap) while pending is set; pending then clears.
  - Consequence: digit values never change within a frame.
- load asserted on the same cycle as the frame boundary: the inputs are captured immediately and pending stays 0.
- Repeated load strobes before a boundary: the value captured is the input present at the boundary.
- Decoding: 0–F use standard hex glyphs (A, b, C, d, E, F), active-high internally and inverted at the outputs.
- Reset (rst_n=0 at a clock edge), including mid-slot:
  - State, counters and outputs: state BLANK, slot counter 0, idx 0, pending 0.
  - Shadow registers: digits 0, digit_en 0, dp 0.
  - Outputs: an all 1, seg 7'h7F, dp_n 1, frame_done 0.

## Timing
- All outputs are registered, so pins never glitch during decode.
- an/seg change only on the BLANK→DRIVE and DRIVE→BLANK edges.
- After reset is released, the first DRIVE for digit 0 appears at rising edge BLANK_CYCLES+1, counting the first active edge as 1.
- Each active anode is low for exactly REFRESH_DIV-BLANK_CYCLES cycles.
- Frame period is exactly N_DIGITS*REFRESH_DIV cycles, and frame_done has that same period.
- From load to visible data: at most one frame plus BLANK_CYCLES+1 cycles.
- Counter widths are $clog2(REFRESH_DIV) and $clog2(N_DIGITS), each with a minimum of 1 bit.

## Structure
- Shared package seg7_pkg contains:
  - scan_state_t enum {BLANK, DRIVE}
  - SEG_OFF = 7'h7F
  - the hex glyph constant table
- One sub-module, hex_seg_decode: 4-bit nibble → 7-bit active-high segments, purely combinational.
- The top level holds the FSM, counters, pending flag, shadow registers and output registers.

## Test plan
All scenarios use N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset then load with digits=16'h4321, digit_en=4'hF, dp=0:
  - Shadow data is 0 until the first boundary.
  - In frame 2, digit 0 drives an=4'b1110 with seg=7'b1111001 ("1") for 6 cycles.
  - Digit 3 drives an=4'b0111 with seg=7'b0011001 ("4").
- Free run for 3 frames: frame_done pulses every 32 cycles for one cycle, and an is all 1 for exactly 2 cycles at the start of every slot.
- digit_en=4'b0101, dp=4'b0100: digits 1 and 3 keep an all 1 through their whole slot; digit 2 drives dp_n=0 and the other digits dp_n=1.
- load asserted mid-frame (digits 16'hABCD) and again with 16'hEF01 before the boundary: the current frame is unchanged and the next frame shows 16'hEF01.
- load coincident with the frame_done boundary: the new data is visible in the immediately following frame and pending is not left set.
- rst_n low for one cycle mid-DRIVE: the next edge gives an all 1, seg 7'h7F, frame_done 0, and the scan restarts at digit 0 with blank shadow data.
